// File: rtl/id_stage.sv
// Instruction-decode stage: register file, field decode, sign extension,
// load-use hazard detection and the registered ID/EX bundle.
module id_stage #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  input  logic            i_flush,
  input  logic            ex_ld,
  input  logic [4:0]      ex_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [5:0]      o_op,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_rs1_val,
  output logic [XLEN-1:0] o_rs2_val,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_br_tgt,
  output logic            o_wr_en,
  output logic            o_ld,
  output logic            o_st,
  output logic            o_br,
  output logic            o_jmp,
  output logic            o_illegal
);

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_SW   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_JMP  = 6'h19;

  logic [XLEN-1:0] r_regs [NREG];

  logic [5:0]      w_op;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic            w_wr, w_ld, w_st, w_br, w_jmp, w_illegal, w_uses_rs2;
  logic [XLEN-1:0] w_imm, w_br_tgt, w_rs1_val, w_rs2_val;
  logic            w_haz, w_issue;

  assign w_op  = i_instr[31:26];
  assign w_rd  = i_instr[25:21];
  assign w_rs1 = i_instr[20:16];
  // Stores carry their data register in the rd slot.
  assign w_rs2 = (w_op == OP_SW) ? i_instr[25:21] : i_instr[15:11];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_wr       = 1'b0;
    w_ld       = 1'b0;
    w_st       = 1'b0;
    w_br       = 1'b0;
    w_jmp      = 1'b0;
    w_illegal  = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        w_wr       = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_ADDI: w_wr = 1'b1;
      OP_LW: begin
        w_wr = 1'b1;
        w_ld = 1'b1;
      end
      OP_SW: begin
        w_st       = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        w_br       = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_JMP:  w_jmp = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_imm    = w_jmp ? {{(XLEN-26){i_instr[25]}}, i_instr[25:0]}
                          : {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};
  assign w_br_tgt = i_pc + (w_imm << 2);

  // Write-through lets an instruction see the value being written back this cycle.
  assign w_rs1_val = (w_rs1 == 5'd0)                 ? '0      :
                     (wb_en && (wb_addr == w_rs1))   ? wb_data : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0)                 ? '0      :
                     (wb_en && (wb_addr == w_rs2))   ? wb_data : r_regs[w_rs2];

  assign w_haz   = i_valid && ex_ld && (ex_rd != 5'd0) &&
                   ((ex_rd == w_rs1) || (w_uses_rs2 && (ex_rd == w_rs2)));
  assign o_stall = w_haz && !i_flush && !rst;
  assign w_issue = i_valid && !i_flush && !w_haz;

  // NOTE: the register file is reset explicitly because all architectural
  // registers must read zero after reset; this rules out a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_pc      <= '0;
      o_op      <= '0;
      o_rd      <= '0;
      o_rs1_val <= '0;
      o_rs2_val <= '0;
      o_imm     <= '0;
      o_br_tgt  <= '0;
      o_wr_en   <= 1'b0;
      o_ld      <= 1'b0;
      o_st      <= 1'b0;
      o_br      <= 1'b0;
      o_jmp     <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      o_valid   <= w_issue;
      o_pc      <= i_pc;
      o_op      <= w_op;
      o_rd      <= w_rd;
      o_rs1_val <= w_rs1_val;
      o_rs2_val <= w_rs2_val;
      o_imm     <= w_imm;
      o_br_tgt  <= w_br_tgt;
      o_wr_en   <= w_issue && w_wr && (w_rd != 5'd0);
      o_ld      <= w_issue && w_ld;
      o_st      <= w_issue && w_st;
      o_br      <= w_issue && w_br;
      o_jmp     <= w_issue && w_jmp;
      o_illegal <= w_issue && w_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic, all checked
// against a table-driven reference model of the decode rules.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_flush, ex_ld, wb_en;
  logic [31:0] i_pc, i_instr, wb_data;
  logic [4:0]  ex_rd, wb_addr;
  logic        o_stall, o_valid, o_wr_en, o_ld, o_st, o_br, o_jmp, o_illegal;
  logic [31:0] o_pc, o_rs1_val, o_rs2_val, o_imm, o_br_tgt;
  logic [5:0]  o_op;
  logic [4:0]  o_rd;

  int n_checks = 0;
  int n_errors = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_pc(i_pc), .i_instr(i_instr),
    .i_flush(i_flush), .ex_ld(ex_ld), .ex_rd(ex_rd), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .o_stall(o_stall), .o_valid(o_valid),
    .o_pc(o_pc), .o_op(o_op), .o_rd(o_rd), .o_rs1_val(o_rs1_val),
    .o_rs2_val(o_rs2_val), .o_imm(o_imm), .o_br_tgt(o_br_tgt), .o_wr_en(o_wr_en),
    .o_ld(o_ld), .o_st(o_st), .o_br(o_br), .o_jmp(o_jmp), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: property tables per opcode and an architectural register array.
  bit          tbl_legal [64];
  bit          tbl_wr    [64];
  bit          tbl_rs2   [64];
  logic [31:0] model_regs [32];

  typedef struct {
    bit          stall, valid, wr, ld, st, br, jmp, ill;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc, rs1v, rs2v, imm, tgt;
  } exp_t;

  function automatic logic [31:0] read_reg(int idx);
    if (idx == 0) return 32'h0;
    if (wb_en && int'(wb_addr) == idx) return wb_data;
    return model_regs[idx];
  endfunction

  function automatic exp_t predict();
    exp_t   e;
    int     op, rs1, rs2;
    longint off;
    bit     haz;
    op  = int'(i_instr[31:26]);
    rs1 = int'(i_instr[20:16]);
    rs2 = (op == 'h11) ? int'(i_instr[25:21]) : int'(i_instr[15:11]);
    if (op == 'h19) begin
      off = longint'(i_instr[25:0]);
      if (off >= 2**25) off -= 2**26;
    end else begin
      off = longint'(i_instr[15:0]);
      if (off >= 2**15) off -= 2**16;
    end
    haz = i_valid && ex_ld && ex_rd != 0 &&
          (int'(ex_rd) == rs1 || (tbl_rs2[op] && int'(ex_rd) == rs2));
    e.stall = haz && !i_flush;
    e.valid = i_valid && !i_flush && !haz;
    e.op    = i_instr[31:26];
    e.rd    = i_instr[25:21];
    e.pc    = i_pc;
    e.rs1v  = read_reg(rs1);
    e.rs2v  = read_reg(rs2);
    e.imm   = 32'(off);
    e.tgt   = 32'(longint'(i_pc) + off * 4);
    e.wr    = e.valid && tbl_wr[op] && e.rd != 0;
    e.ld    = e.valid && op == 'h10;
    e.st    = e.valid && op == 'h11;
    e.br    = e.valid && op == 'h18;
    e.jmp   = e.valid && op == 'h19;
    e.ill   = e.valid && !tbl_legal[op];
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, "_valid"}, o_valid, e.valid);
    check({tag, "_wr"},    o_wr_en, e.wr);
    check({tag, "_ld"},    o_ld, e.ld);
    check({tag, "_st"},    o_st, e.st);
    check({tag, "_br"},    o_br, e.br);
    check({tag, "_jmp"},   o_jmp, e.jmp);
    check({tag, "_ill"},   o_illegal, e.ill);
    if (e.valid) begin
      check({tag, "_pc"},  o_pc, e.pc);
      check({tag, "_op"},  o_op, e.op);
      check({tag, "_rd"},  o_rd, e.rd);
      check({tag, "_rs1"}, o_rs1_val, e.rs1v);
      check({tag, "_rs2"}, o_rs2_val, e.rs2v);
      check({tag, "_imm"}, o_imm, e.imm);
      check({tag, "_tgt"}, o_br_tgt, e.tgt);
    end
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic cycle(input string tag);
    exp_t e;
    #1;
    e = predict();
    check({tag, "_stall"}, o_stall, e.stall);
    @(posedge clk);
    if (wb_en && wb_addr != 0) model_regs[wb_addr] = wb_data;
    #1;
    compare(tag, e);
    @(negedge clk);
  endtask

  task automatic idle();
    i_valid = 0; i_flush = 0; ex_ld = 0; ex_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] ins);
    i_valid = 1; i_pc = pc; i_instr = ins;
  endtask

  function automatic logic [31:0] ins_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h0};
  endfunction

  function automatic logic [31:0] ins_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  initial begin
    logic [5:0] ops [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h10, 6'h11, 6'h18, 6'h19};
    foreach (tbl_legal[i]) begin
      tbl_legal[i] = i inside {'h00, 'h01, 'h02, 'h03, 'h04, 'h08, 'h10, 'h11, 'h18, 'h19};
      tbl_wr[i]    = i inside {'h01, 'h02, 'h03, 'h04, 'h08, 'h10};
      tbl_rs2[i]   = i inside {'h01, 'h02, 'h03, 'h04, 'h11, 'h18};
    end
    foreach (model_regs[i]) model_regs[i] = 32'h0;

    rst = 1; idle(); i_pc = 0; i_instr = 0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_pc", o_pc, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Fill a register, issue something, then reset mid-cycle with a live hazard.
    wb_en = 1; wb_addr = 9; wb_data = 32'h5555_AAAA; cycle("pre_wb"); idle();
    present(32'h44, ins_i(6'h08, 5'd2, 5'd9, 16'h0007)); cycle("pre_addi"); idle();
    present(32'h48, ins_r(6'h01, 5'd1, 5'd4, 5'd0)); ex_ld = 1; ex_rd = 4;
    #2; rst = 1; #1;
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_pc", o_pc, 0);
    check("rst_mid_rs1", o_rs1_val, 0);
    check("rst_mid_imm", o_imm, 0);
    check("rst_mid_wr", o_wr_en, 0);
    check("rst_mid_stall", o_stall, 0);
    foreach (model_regs[i]) model_regs[i] = 32'h0;
    @(negedge clk); rst = 0; idle();

    present(32'h10, ins_r(6'h01, 5'd1, 5'd9, 5'd0)); cycle("rst_regs_clear");
    check("rst_r9_zero", o_rs1_val, 0);
    idle(); wb_en = 1; wb_addr = 5; wb_data = 32'h1234; cycle("wb_r5"); idle();
    present(32'h14, ins_r(6'h01, 5'd3, 5'd5, 5'd0)); cycle("add");
    check("add_rs1", o_rs1_val, 32'h1234);
    check("add_wr", o_wr_en, 1);

    // Write-through and r0.
    present(32'h18, ins_i(6'h08, 5'd1, 5'd7, 16'hFFFC));
    wb_en = 1; wb_addr = 7; wb_data = 32'hDEADBEEF; cycle("wt");
    check("wt_rs1", o_rs1_val, 32'hDEADBEEF);
    check("wt_imm", o_imm, 32'hFFFF_FFFC);
    idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF; cycle("wb_r0"); idle();
    present(32'h1C, ins_r(6'h01, 5'd1, 5'd0, 5'd0)); cycle("rd_r0");
    check("r0_zero", o_rs1_val, 0);

    // Load-use: one bubble, then reissue; write-through during the stall is kept.
    present(32'h20, ins_r(6'h02, 5'd2, 5'd4, 5'd6)); ex_ld = 1; ex_rd = 4;
    wb_en = 1; wb_addr = 4; wb_data = 32'h0BAD_F00D; cycle("lu_stall");
    check("lu_bubble", o_valid, 0);
    ex_ld = 0; wb_en = 0; cycle("lu_issue");
    check("lu_issue_valid", o_valid, 1);
    check("lu_issue_rs1", o_rs1_val, 32'h0BAD_F00D);
    present(32'h24, ins_r(6'h02, 5'd2, 5'd0, 5'd6)); ex_ld = 1; ex_rd = 0; cycle("lu_rd0");
    check("lu_rd0_valid", o_valid, 1);

    // Flush beats a hazard.
    present(32'h28, ins_r(6'h02, 5'd2, 5'd4, 5'd6)); ex_ld = 1; ex_rd = 6; i_flush = 1;
    cycle("flush"); idle();

    present(32'h10, ins_i(6'h18, 5'd1, 5'd2, 16'hFFFF)); cycle("beq");
    check("beq_tgt", o_br_tgt, 32'h0000_000C);
    present(32'h100, {6'h19, 26'h3FF_FFFF}); cycle("jmp");
    check("jmp_tgt", o_br_tgt, 32'h0000_00FC);
    present(32'h2C, ins_r(6'h3F, 5'd5, 5'd1, 5'd2)); cycle("illegal");
    check("illegal_flag", o_illegal, 1);
    present(32'h30, ins_r(6'h01, 5'd3, 5'd1, 5'd2)); i_valid = 0; cycle("invalid");

    // Randomized traffic on a small register window to hit hazards and write-through.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      i_valid = ($urandom_range(0, 99) < 85);
      i_flush = ($urandom_range(0, 99) < 10);
      i_pc    = $urandom;
      i_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 11'($urandom)};
      ex_ld   = $urandom_range(0, 1);
      ex_rd   = 5'($urandom_range(0, 7));
      wb_en   = $urandom_range(0, 1);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
